johnson_ring_gen: RTL and testbench

Parametrised shift-register counter, successor to the fixed 4-bit twisted-ring counter. It supports any width and a runtime-selectable ring (one-hot) or twisted-ring (Johnson) mode. It also provides count enable, direction control, parallel load with legality checking, and a binary phase index. It self-corrects illegal states and emits a one-cycle wrap pulse per full period. It is a stand-alone sequencer block used to generate phase/strobe patterns for downstream logic.

---
 rtl/johnson_ring_gen.sv | 126 ++++++++++++
 tb/tb_johnson_ring_gen.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/johnson_ring_gen.sv
// Width-parametrised ring (one-hot) / twisted-ring (Johnson) counter with
// load legality checking, direction control, phase index and wrap/err pulses.
module johnson_ring_gen #(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned PW    = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic [PW-1:0]    phase,
  output logic             wrap,
  output logic             err
);

  localparam int unsigned WP1 = WIDTH + 1;

  logic [WIDTH-1:0] out_q, out_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             mode_q, mode_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  function automatic logic [WIDTH-1:0] seed_of(input logic m);
    return m ? '0 : WIDTH'(1);
  endfunction

  function automatic int unsigned ones_of(input logic [WIDTH-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < WIDTH; i++) n = n + 32'(v[i]);
    return n;
  endfunction

  // Mask with the n lowest bits set (n may equal WIDTH).
  function automatic logic [WIDTH-1:0] low_mask(input int unsigned n);
    logic [WIDTH:0] t;
    t = WP1'(1) << n;
    return WIDTH'(t - WP1'(1));
  endfunction

  function automatic logic is_legal(input logic m, input logic [WIDTH-1:0] v);
    int unsigned n;
    n = ones_of(v);
    if (!m) return (n == 1);
    return (v == low_mask(n)) || (v == ~low_mask(WIDTH - n));
  endfunction

  function automatic logic [PW-1:0] phase_of(input logic m, input logic [WIDTH-1:0] v);
    int unsigned n;
    logic [PW-1:0] idx;
    idx = '0;
    if (!m) begin
      for (int unsigned i = 0; i < WIDTH; i++) if (v[i]) idx = PW'(i);
      return idx;
    end
    n = ones_of(v);
    if (v[0] || n == 0) return PW'(n);
    return PW'(2 * WIDTH - n);
  endfunction

  function automatic logic [WIDTH-1:0] step_of(input logic m, input logic d,
                                               input logic [WIDTH-1:0] v);
    if (!d) return {v[WIDTH-2:0], m ? ~v[WIDTH-1] : v[WIDTH-1]};
    return {m ? ~v[0] : v[0], v[WIDTH-1:1]};
  endfunction

  function automatic logic [PW-1:0] phase_step(input logic m, input logic d,
                                               input logic [PW-1:0] p);
    int unsigned per, cur;
    per = m ? 2 * WIDTH : WIDTH;
    cur = 32'(p);
    if (!d) return (cur + 1 == per) ? '0 : PW'(cur + 1);
    return (cur == 0) ? PW'(per - 1) : PW'(cur - 1);
  endfunction

  // Next-state selection in priority order: reset, mode change, correction, load, step.
  always_comb begin
    out_d   = out_q;
    phase_d = phase_q;
    mode_d  = mode_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (rst || (mode != mode_q)) begin
      out_d   = seed_of(mode);
      phase_d = '0;
      mode_d  = mode;
    end else if (!is_legal(mode_q, out_q)) begin
      out_d   = seed_of(mode_q);
      phase_d = '0;
      err_d   = 1'b1;
    end else if (load) begin
      if (is_legal(mode_q, load_val)) begin
        out_d   = load_val;
        phase_d = phase_of(mode_q, load_val);
      end else begin
        out_d   = seed_of(mode_q);
        phase_d = '0;
        err_d   = 1'b1;
      end
    end else if (en) begin
      out_d   = step_of(mode_q, dir, out_q);
      phase_d = phase_step(mode_q, dir, phase_q);
      wrap_d  = (out_d == seed_of(mode_q));
    end
  end

  // Reset is folded into the next-state logic, so the register is a plain sync flop.
  always_ff @(posedge clk) begin
    out_q   <= out_d;
    phase_q <= phase_d;
    mode_q  <= mode_d;
    wrap_q  <= wrap_d;
    err_q   <= err_d;
  end

  assign out   = out_q;
  assign phase = phase_q;
  assign wrap  = wrap_q;
  assign err   = err_q;

endmodule

// File: tb/tb_johnson_ring_gen.sv
// Directed-vector bench for johnson_ring_gen (WIDTH=4) with a queue scoreboard.
module tb_johnson_ring_gen;

  localparam int unsigned W  = 4;
  localparam int unsigned PW = 3;

  logic          clk = 1'b0;
  logic          rst, en, dir, mode, load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  out;
  logic [PW-1:0] phase;
  logic          wrap, err;

  int checks = 0;
  int errors = 0;

  johnson_ring_gen #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .out(out), .phase(phase), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          r, e, d, m, l;
    logic [W-1:0]  lv;
    logic          frc;
    logic [W-1:0]  eo;
    logic [PW-1:0] ep;
    logic          ew, ee;
  } vec_t;

  typedef struct {
    int            idx;
    logic [W-1:0]  o;
    logic [PW-1:0] p;
    logic          w, e;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];

  task automatic add(input logic r, e, d, m, l, input logic [W-1:0] lv, input logic frc,
                     input logic [W-1:0] eo, input int ep, input logic ew, ee);
    vec_t v;
    v.r = r; v.e = e; v.d = d; v.m = m; v.l = l; v.lv = lv; v.frc = frc;
    v.eo = eo; v.ep = PW'(ep); v.ew = ew; v.ee = ee;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL vec%0d %s: got %0h expected %0h", idx, nm, got, exp);
    end
  endtask

  // Monitor: every cycle presents an output; compare against the oldest expectation.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("out",   x.idx, 32'(out),   32'(x.o));
      chk("phase", x.idx, 32'(phase), 32'(x.p));
      chk("wrap",  x.idx, 32'(wrap),  32'(x.w));
      chk("err",   x.idx, 32'(err),   32'(x.e));
    end
  end

  initial begin
    exp_t x;
    //    rst en dir md ld load_val frc  out    ph w  e
    add(1, 0, 0, 1, 0, 4'b0000, 0, 4'b0000, 0, 0, 0);  // reset, twisted
    add(0, 1, 0, 1, 0, 4'b0000, 0, 4'b0001, 1, 0, 0);
    add(0, 1, 0, 1, 0, 4'b0000, 0, 4'b0011, 2, 0, 0);
    add(0, 1, 0, 1, 0, 4'b0000, 0, 4'b0111, 3, 0, 0);
    add(0, 1, 0, 1, 0, 4'b0000, 0, 4'b1111, 4, 0, 0);
    add(0, 1, 0, 1, 0, 4'b0000, 0, 4'b1110, 5, 0, 0);
    add(0, 1, 0, 1, 0, 4'b0000, 0, 4'b1100, 6, 0, 0);
    add(0, 1, 0, 1, 0, 4'b0000, 0, 4'b1000, 7, 0, 0);
    add(0, 1, 0, 1, 0, 4'b0000, 0, 4'b0000, 0, 1, 0);  // wrap at seed
    add(0, 1, 0, 0, 0, 4'b0000, 0, 4'b0001, 0, 0, 0);  // mode change to ring
    add(0, 1, 0, 0, 0, 4'b0000, 0, 4'b0010, 1, 0, 0);
    add(0, 1, 0, 0, 0, 4'b0000, 0, 4'b0100, 2, 0, 0);
    add(0, 1, 0, 0, 0, 4'b0000, 0, 4'b1000, 3, 0, 0);
    add(0, 1, 0, 0, 0, 4'b0000, 0, 4'b0001, 0, 1, 0);
    add(0, 1, 1, 0, 0, 4'b0000, 0, 4'b1000, 3, 0, 0);  // right step, no dead cycle
    add(0, 1, 1, 0, 0, 4'b0000, 0, 4'b0100, 2, 0, 0);
    add(0, 1, 1, 0, 0, 4'b0000, 0, 4'b0010, 1, 0, 0);
    add(0, 1, 1, 0, 0, 4'b0000, 0, 4'b0001, 0, 1, 0);  // right arrival at seed
    add(0, 0, 0, 1, 0, 4'b0000, 0, 4'b0000, 0, 0, 0);  // mode change to twisted
    add(0, 0, 0, 1, 1, 4'b1110, 0, 4'b1110, 5, 0, 0);  // legal load
    add(0, 0, 0, 1, 1, 4'b1010, 0, 4'b0000, 0, 0, 1);  // illegal load
    add(0, 1, 0, 1, 1, 4'b0011, 0, 4'b0011, 2, 0, 0);  // load beats en
    add(0, 1, 1, 1, 0, 4'b0000, 0, 4'b0001, 1, 0, 0);
    add(0, 1, 1, 1, 0, 4'b0000, 0, 4'b0000, 0, 1, 0);
    add(0, 1, 1, 1, 0, 4'b0000, 0, 4'b1000, 7, 0, 0);  // phase underflow
    add(0, 1, 0, 1, 0, 4'b0000, 0, 4'b0000, 0, 1, 0);
    add(0, 1, 0, 1, 0, 4'b0000, 0, 4'b0001, 1, 0, 0);
    add(0, 1, 0, 1, 0, 4'b0000, 0, 4'b0011, 2, 0, 0);
    add(0, 1, 0, 1, 0, 4'b0000, 0, 4'b0111, 3, 0, 0);
    add(0, 1, 0, 0, 1, 4'b0100, 0, 4'b0001, 0, 0, 0);  // mode change beats load+en
    add(0, 1, 0, 0, 0, 4'b0000, 0, 4'b0010, 1, 0, 0);
    add(0, 0, 0, 0, 1, 4'b1000, 0, 4'b1000, 3, 0, 0);  // ring load
    add(0, 0, 0, 0, 1, 4'b0110, 0, 4'b0001, 0, 0, 1);  // ring illegal load
    add(0, 0, 0, 0, 1, 4'b0000, 0, 4'b0001, 0, 0, 1);
    add(0, 0, 0, 0, 0, 4'b0000, 0, 4'b0001, 0, 0, 0);
    add(0, 0, 0, 1, 0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    add(0, 1, 0, 1, 0, 4'b0000, 0, 4'b0001, 1, 0, 0);
    add(0, 1, 0, 1, 0, 4'b0000, 0, 4'b0011, 2, 0, 0);
    add(0, 1, 0, 1, 1, 4'b1111, 1, 4'b0000, 0, 0, 1);  // corrupted state corrected
    add(0, 1, 0, 1, 0, 4'b0000, 0, 4'b0001, 1, 0, 0);
    add(0, 1, 0, 1, 0, 4'b0000, 0, 4'b0011, 2, 0, 0);
    add(1, 1, 0, 1, 1, 4'b0111, 0, 4'b0000, 0, 0, 0);  // reset beats load+en
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 1, 0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    add(0, 1, 0, 1, 0, 4'b0000, 0, 4'b0001, 1, 0, 0);
    add(1, 0, 0, 0, 0, 4'b0000, 0, 4'b0001, 0, 0, 0);  // reset into ring
    add(0, 1, 0, 0, 0, 4'b0000, 0, 4'b0010, 1, 0, 0);

    rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b1; load = 1'b0; load_val = '0;
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      if (vq[i].frc) begin
        force dut.out_q = 4'b0101;
        #1;
        release dut.out_q;
      end
      rst = vq[i].r; en = vq[i].e; dir = vq[i].d; mode = vq[i].m;
      load = vq[i].l; load_val = vq[i].lv;
      x.idx = i; x.o = vq[i].eo; x.p = vq[i].ep; x.w = vq[i].ew; x.e = vq[i].ee;
      sb.push_back(x);
    end
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
